cga_vram_arbiter: RTL and testbench
===================================

Name: cga_vram_arbiter

Overview:
- Shares the single-port CGA/Tandy video RAM between the display fetch path (sequencer/CRTC addresses) and ISA-bus CPU memory reads and writes.
- Video fetches always have priority. CPU accesses are scheduled into sequencer-granted slots.
- Holds the ISA bus with wait states (bus_rdy low) until a slot completes.
- Sits between cga_sequencer/crtc6845 address generation and the external RAM port, in the cga top level.

Parameters:
- ADDR_BITS, 15, width of the VRAM word address (32 KB Tandy window).
- USE_BUS_WAIT, 1, 1 = drive bus_rdy wait states; 0 = bus_rdy tied 1 (arbitration still performed).
- SYNC_STAGES, 2, synchronizer depth for bus_memr_l/bus_memw_l (legal values 2 or 3).

Ports:
- clk  in  1  system pixel clock
- reset  in  1  asynchronous, active-high reset
- video_req  in  1  sequencer VRAM fetch this cycle (vram_read)
- video_addr  in  ADDR_BITS  display fetch address (already interlace-mapped)
- cpu_slot  in  1  sequencer CPU window (isa_op_enable)
- bus_mem_cs  in  1  decoded framebuffer hit (B8000-BFFFF)
- bus_a  in  ADDR_BITS  ISA address
- bus_memr_l  in  1  ISA memory read strobe, active low
- bus_memw_l  in  1  ISA memory write strobe, active low
- bus_d  in  8  ISA write data
- bus_out  out  8  CPU read data
- bus_dir  out  1  1 = drive bus_out onto ISA
- bus_rdy  out  1  ISA ready; 0 = wait state
- ram_a  out  ADDR_BITS  RAM address
- ram_we_l  out  1  RAM write enable, active low
- ram_wdata  out  8  RAM write data
- ram_d  in  8  RAM read data, valid one clk after ram_a
- snow  out  1  pulse: video fetch received CPU data (macro only; else 0)

Behaviour:
- Reset values: state IDLE, bus_rdy=1, bus_dir=0, bus_out=0, ram_we_l=1, ram_wdata=0, snow=0; sync flops = 1 (inactive).
- Strobes pass through SYNC_STAGES flops; bus_a/bus_d are sampled at request detection and held in cpu_addr/cpu_wdata.
- Request = bus_mem_cs & (synced memr low | synced memw low). If both strobes are low, it is treated as a write.
- ram_a = video_addr whenever video_req=1 or state ∉ {ACCESS, LATCH}; otherwise ram_a = cpu_addr.
- FSM:
  - IDLE: on request, latch address/data/direction, bus_rdy←0 (if USE_BUS_WAIT), go to WAIT_SLOT.
  - WAIT_SLOT: when cpu_slot=1 and video_req=0, go to ACCESS. Wait indefinitely otherwise.
  - ACCESS (1 clk): ram_a=cpu_addr; on write, ram_we_l=0 and ram_wdata=cpu_wdata. Write → DONE; read → LATCH.
  - LATCH (1 clk): if video_req=0, bus_out←ram_d and go to DONE. If video_req=1, abort, go back to WAIT_SLOT, and retry the whole read.
  - DONE: bus_rdy=1; bus_dir=1 for reads. Stay until both synced strobes are high, then bus_dir←0 and go to IDLE. bus_out holds its last value.
- Minimum CPU latency from synced strobe to bus_rdy=1:
  - write: 2 clk (IDLE→WAIT_SLOT→ACCESS→DONE, with slot open);
  - read: 3 clk.
- Strobe deasserted while in WAIT_SLOT (bus aborted): return to IDLE with no RAM access and bus_rdy←1.
- Reset mid-access: immediate return to reset values; a pending write is dropped, never half-written.
- ram_we_l is low for exactly one clk per write, and never while video_req=1 (without macro).
- Addresses wrap within ADDR_BITS; no carry out.

Optional Feature:
- Macro: CGA_SNOW_EN.
- Defined:
  - WAIT_SLOT does not wait for cpu_slot; ACCESS is entered on the first WAIT_SLOT clk regardless of video_req.
  - If video_req=1 during ACCESS or LATCH, the CPU address wins ram_a, and snow pulses 1 for that clk (the video path sees CPU data, i.e. genuine CGA snow).
  - LATCH never aborts.
- Undefined: behaviour exactly as above, snow held at 0.

Test Plan:
- Reset asserted mid-WAIT_SLOT with bus_memw_l low → ram_we_l stays 1, bus_rdy=1, state IDLE the same clk; after release, no write to RAM.
- Write bus_a=15'h0123, bus_d=8'hA5, cpu_slot held 1, video_req 0 → exactly one clk with ram_we_l=0, ram_a=0123, ram_wdata=A5; bus_rdy low 2 clk after synced strobe, then high until strobe rises.
- Read bus_a=15'h7FFF, RAM model returns 8'h3C, slot open → bus_out=3C, bus_dir=1 while strobe low; bus_dir=0 the clk after synced strobe high.
- Read with video_req rising in LATCH → abort/retry: ram_a shows video_addr that clk; bus_out correct only after the next slot; bus_rdy stays 0 until then.
- cpu_slot held 0 for 40 clk during a pending write → bus_rdy=0 for all 40 clk, ram_we_l never 0; write completes within 2 clk of cpu_slot=1.
- CGA_SNOW_EN build: write with video_req=1 constant → write completes 2 clk after detection, snow=1 for one clk, ram_a=cpu_addr that clk. Non-macro build: snow stays 0.

Source files
------------

// File: rtl/cga_vram_arbiter_if.sv
// Signal bundle between the CGA display/ISA side and the VRAM arbiter.
// The master modport is the host side (sequencer, ISA bus, RAM chip); the slave modport is the arbiter.
interface cga_vram_arbiter_if #(
    parameter int ADDR_BITS = 15
);
    logic                 video_req;
    logic [ADDR_BITS-1:0] video_addr;
    logic                 cpu_slot;
    logic                 bus_mem_cs;
    logic [ADDR_BITS-1:0] bus_a;
    logic                 bus_memr_l;
    logic                 bus_memw_l;
    logic [7:0]           bus_d;
    logic [7:0]           bus_out;
    logic                 bus_dir;
    logic                 bus_rdy;
    logic [ADDR_BITS-1:0] ram_a;
    logic                 ram_we_l;
    logic [7:0]           ram_wdata;
    logic [7:0]           ram_d;
    logic                 snow;

    modport master (
        output video_req, video_addr, cpu_slot, bus_mem_cs, bus_a,
               bus_memr_l, bus_memw_l, bus_d, ram_d,
        input  bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_wdata, snow
    );

    modport slave (
        input  video_req, video_addr, cpu_slot, bus_mem_cs, bus_a,
               bus_memr_l, bus_memw_l, bus_d, ram_d,
        output bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_wdata, snow
    );
endinterface

// File: rtl/cga_vram_arbiter.sv
// CGA/Tandy VRAM arbiter: video fetches own the RAM, ISA CPU cycles are slotted in with wait states.
// Optional macro CGA_SNOW_EN: CPU accesses ignore the slot and steal the RAM from video, producing snow.
module cga_vram_arbiter #(
    parameter int ADDR_BITS    = 15,
    parameter int USE_BUS_WAIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    cga_vram_arbiter_if.slave vif
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SLOT = 3'd1;
    localparam logic [2:0] ST_ACCESS    = 3'd2;
    localparam logic [2:0] ST_LATCH     = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    logic [2:0]             state_r;
    logic [2:0]             state_nx_s;
    logic [SYNC_STAGES-1:0] memr_sync_r;
    logic [SYNC_STAGES-1:0] memw_sync_r;
    logic [ADDR_BITS-1:0]   cpu_addr_r;
    logic [7:0]             cpu_wdata_r;
    logic                   cpu_write_r;
    logic [7:0]             bus_out_r;
    logic                   bus_dir_r;
    logic                   bus_rdy_r;

    logic                   rd_act_s;
    logic                   wr_act_s;
    logic                   strobe_s;
    logic                   request_s;
    logic                   cpu_phase_s;
    logic                   cpu_owns_ram_s;
    logic                   slot_ok_s;
    logic                   video_clash_s;
    logic                   snow_s;

    assign rd_act_s    = ~memr_sync_r[SYNC_STAGES-1];
    assign wr_act_s    = ~memw_sync_r[SYNC_STAGES-1];
    assign strobe_s    = rd_act_s | wr_act_s;
    assign request_s   = vif.bus_mem_cs & strobe_s;
    assign cpu_phase_s = (state_r == ST_ACCESS) || (state_r == ST_LATCH);

`ifdef CGA_SNOW_EN
    // CPU steals the RAM unconditionally; any overlapping video fetch sees CPU data.
    assign cpu_owns_ram_s = cpu_phase_s;
    assign slot_ok_s      = 1'b1;
    assign video_clash_s  = 1'b0;
    assign snow_s         = cpu_phase_s & vif.video_req;
`else
    // A video fetch landing in a CPU phase takes the RAM and forces the CPU access to retry.
    assign cpu_owns_ram_s = cpu_phase_s & ~vif.video_req;
    assign slot_ok_s      = vif.cpu_slot & ~vif.video_req;
    assign video_clash_s  = vif.video_req;
    assign snow_s         = 1'b0;
`endif

    assign vif.ram_a     = cpu_owns_ram_s ? cpu_addr_r : vif.video_addr;
    assign vif.ram_we_l  = ~((state_r == ST_ACCESS) & cpu_write_r & cpu_owns_ram_s);
    assign vif.ram_wdata = cpu_wdata_r;
    assign vif.snow      = snow_s;
    assign vif.bus_out   = bus_out_r;
    assign vif.bus_dir   = bus_dir_r;
    assign vif.bus_rdy   = (USE_BUS_WAIT != 0) ? bus_rdy_r : 1'b1;

    // Strobe synchronizers, idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memr_sync_r <= {SYNC_STAGES{1'b1}};
            memw_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            memr_sync_r <= {memr_sync_r[SYNC_STAGES-2:0], vif.bus_memr_l};
            memw_sync_r <= {memw_sync_r[SYNC_STAGES-2:0], vif.bus_memw_l};
        end
    end

    // Next-state logic for the CPU access sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (request_s) state_nx_s = ST_WAIT_SLOT;
                else           state_nx_s = ST_IDLE;
            end
            ST_WAIT_SLOT: begin
                if (!strobe_s)      state_nx_s = ST_IDLE;
                else if (slot_ok_s) state_nx_s = ST_ACCESS;
                else                state_nx_s = ST_WAIT_SLOT;
            end
            ST_ACCESS: begin
                if (video_clash_s)    state_nx_s = ST_WAIT_SLOT;
                else if (cpu_write_r) state_nx_s = ST_DONE;
                else                  state_nx_s = ST_LATCH;
            end
            ST_LATCH: begin
                if (video_clash_s) state_nx_s = ST_WAIT_SLOT;
                else               state_nx_s = ST_DONE;
            end
            ST_DONE: begin
                if (!strobe_s) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nx_s;
    end

    // Request capture and ISA-side outputs; ready is high exactly in IDLE and DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_addr_r  <= {ADDR_BITS{1'b0}};
            cpu_wdata_r <= 8'h00;
            cpu_write_r <= 1'b0;
            bus_out_r   <= 8'h00;
            bus_dir_r   <= 1'b0;
            bus_rdy_r   <= 1'b1;
        end else begin
            if ((state_r == ST_IDLE) && request_s) begin
                cpu_addr_r  <= vif.bus_a;
                cpu_wdata_r <= vif.bus_d;
                cpu_write_r <= wr_act_s;
            end
            if ((state_r == ST_LATCH) && (state_nx_s == ST_DONE)) begin
                bus_out_r <= vif.ram_d;
            end
            bus_rdy_r <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_DONE);
            bus_dir_r <= (state_nx_s == ST_DONE) & ~cpu_write_r;
        end
    end

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Self-checking bench for cga_vram_arbiter: directed scenarios plus randomized traffic
// checked against a plain memory-array reference; build with +define+CGA_SNOW_EN for the snow variant.
module tb_cga_vram_arbiter;
    localparam int AB = 15;
    localparam int MEM_WORDS = 1 << AB;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cga_vram_arbiter_if #(.ADDR_BITS(AB)) vif ();

    cga_vram_arbiter #(.ADDR_BITS(AB), .USE_BUS_WAIT(1), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    logic [7:0]    ram     [0:MEM_WORDS-1];
    logic [7:0]    ref_mem [0:MEM_WORDS-1];
    int            we_cycles = 0;
    int            we_clash = 0;
    int            snow_cycles = 0;
    logic [AB-1:0] last_we_addr;
    logic [7:0]    last_we_data;

    // External RAM chip: synchronous write, read data one clock after the address.
    always @(posedge clk) begin
        if (!vif.ram_we_l) ram[vif.ram_a] <= vif.ram_wdata;
        vif.ram_d <= ram[vif.ram_a];
    end

    // Activity monitor for write strobes and snow.
    always @(posedge clk) begin
        if (vif.ram_we_l === 1'b0) begin
            we_cycles    <= we_cycles + 1;
            last_we_addr <= vif.ram_a;
            last_we_data <= vif.ram_wdata;
            if (vif.video_req === 1'b1) we_clash <= we_clash + 1;
        end
        if (vif.snow === 1'b1) snow_cycles <= snow_cycles + 1;
    end

    task automatic drive_video_random();
        vif.video_req  = ($urandom_range(0, 3) == 0);
        vif.cpu_slot   = ($urandom_range(0, 1) == 1);
        vif.video_addr = AB'($urandom);
    endtask

    // One complete ISA cycle: assert strobe, wait for ready, release, watch bus_dir/bus_rdy.
    task automatic run_cpu(input bit wr, input logic [AB-1:0] a, input logic [7:0] d, input bit rnd,
                           output int low_cnt, output int dir_cnt, output int rdy_drop,
                           output logic [7:0] rd, output bit to);
        bit seen_low;
        seen_low = 1'b0;
        low_cnt = 0; dir_cnt = 0; rdy_drop = 0; to = 1'b1;
        @(negedge clk);
        vif.bus_a = a;
        vif.bus_d = d;
        if (wr) vif.bus_memw_l = 1'b0;
        else    vif.bus_memr_l = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (vif.bus_rdy === 1'b0) begin
                seen_low = 1'b1;
                low_cnt++;
            end else if (seen_low) begin
                to = 1'b0;
                break;
            end
            if (rnd) drive_video_random();
        end
        rd = vif.bus_out;
        vif.bus_memw_l = 1'b1;
        vif.bus_memr_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (vif.bus_dir === 1'b1) dir_cnt++;
            if (vif.bus_rdy !== 1'b1) rdy_drop++;
            if (rnd) drive_video_random();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (vif.bus_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", vif.bus_rdy); end
        total++; if (vif.bus_dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b exp=0", vif.bus_dir); end
        total++; if (vif.bus_out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", vif.bus_out); end
        total++; if (vif.ram_we_l !== 1'b1) begin bad++; $display("FAIL reset_we got=%b exp=1", vif.ram_we_l); end
        total++; if (vif.ram_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", vif.ram_wdata); end
        total++; if (vif.snow !== 1'b0) begin bad++; $display("FAIL reset_snow got=%b exp=0", vif.snow); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int lo, dc, rdp, we0; logic [7:0] rd; bit to;
        we0 = we_cycles;
        run_cpu(1'b1, 15'h0123, 8'hA5, 1'b0, lo, dc, rdp, rd, to);
        ref_mem[15'h0123] = 8'hA5;
        total++; if (to) begin bad++; $display("FAIL wr_timeout got=timeout exp=ready"); end
        total++; if (lo != 2) begin bad++; $display("FAIL wr_wait_cycles got=%0d exp=2", lo); end
        total++; if (we_cycles - we0 != 1) begin bad++; $display("FAIL wr_we_pulses got=%0d exp=1", we_cycles - we0); end
        total++; if (last_we_addr !== 15'h0123) begin bad++; $display("FAIL wr_ram_a got=%h exp=0123", last_we_addr); end
        total++; if (last_we_data !== 8'hA5) begin bad++; $display("FAIL wr_wdata got=%h exp=a5", last_we_data); end
        total++; if (ram[15'h0123] !== ref_mem[15'h0123]) begin bad++; $display("FAIL wr_mem got=%h exp=%h", ram[15'h0123], ref_mem[15'h0123]); end
        total++; if (rdp != 0) begin bad++; $display("FAIL wr_rdy_hold got=%0d drops exp=0", rdp); end
        total++; if (dc != 0) begin bad++; $display("FAIL wr_dir got=%0d exp=0", dc); end
    endtask

    task automatic test_read();
        int lo, dc, rdp; logic [7:0] rd; bit to;
        ram[15'h7FFF] <= 8'h3C;
        ref_mem[15'h7FFF] = 8'h3C;
        run_cpu(1'b0, 15'h7FFF, 8'h00, 1'b0, lo, dc, rdp, rd, to);
        total++; if (to) begin bad++; $display("FAIL rd_timeout got=timeout exp=ready"); end
        total++; if (lo != 3) begin bad++; $display("FAIL rd_wait_cycles got=%0d exp=3", lo); end
        total++; if (rd !== ref_mem[15'h7FFF]) begin bad++; $display("FAIL rd_data got=%h exp=%h", rd, ref_mem[15'h7FFF]); end
        total++; if (dc != 2) begin bad++; $display("FAIL rd_dir_cycles got=%0d exp=2", dc); end
        total++; if (vif.bus_out !== 8'h3C) begin bad++; $display("FAIL rd_out_hold got=%h exp=3c", vif.bus_out); end
    endtask

    task automatic test_read_abort();
        int lo, exp_lo; bit seen_low, to; logic [AB-1:0] exp_a;
        ram[15'h1234] <= 8'h5A; ref_mem[15'h1234] = 8'h5A;
        ram[15'h0456] <= 8'hC3; ref_mem[15'h0456] = 8'hC3;
`ifdef CGA_SNOW_EN
        exp_lo = 3; exp_a = 15'h1234;
`else
        exp_lo = 6; exp_a = 15'h0456;
`endif
        vif.video_addr = 15'h0456;
        lo = 0; seen_low = 1'b0; to = 1'b1;
        @(negedge clk);
        vif.bus_a = 15'h1234;
        vif.bus_memr_l = 1'b0;
        for (int n = 1; n < 200; n++) begin
            @(negedge clk);
            if (vif.bus_rdy === 1'b0) begin
                seen_low = 1'b1;
                lo++;
            end else if (seen_low) begin
                to = 1'b0;
                break;
            end
            if (n == 5) begin
                vif.video_req = 1'b1;
                #1;
                total++; if (vif.ram_a !== exp_a) begin bad++; $display("FAIL abort_ram_a got=%h exp=%h", vif.ram_a, exp_a); end
            end
            if (n == 6) vif.video_req = 1'b0;
        end
        total++; if (to) begin bad++; $display("FAIL abort_timeout got=timeout exp=ready"); end
        total++; if (lo != exp_lo) begin bad++; $display("FAIL abort_wait_cycles got=%0d exp=%0d", lo, exp_lo); end
        total++; if (vif.bus_out !== ref_mem[15'h1234]) begin bad++; $display("FAIL abort_data got=%h exp=%h", vif.bus_out, ref_mem[15'h1234]); end
        vif.bus_memr_l = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_slot_starved();
        int errs, we0, n2; bit done;
        we0 = we_cycles; errs = 0; done = 1'b0; n2 = 0;
        @(negedge clk);
        vif.cpu_slot = 1'b0;
        vif.bus_a = 15'h2222; vif.bus_d = 8'h77;
        vif.bus_memw_l = 1'b0;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (vif.bus_rdy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL starve_rdy got=%0d high cycles exp=0", errs); end
        total++; if (we_cycles != we0) begin bad++; $display("FAIL starve_we got=%0d exp=0", we_cycles - we0); end
        vif.cpu_slot = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (vif.bus_rdy === 1'b1) begin done = 1'b1; n2 = n; break; end
        end
        ref_mem[15'h2222] = 8'h77;
        total++; if (!done || n2 != 2) begin bad++; $display("FAIL starve_finish got=%0d clk exp=2", n2); end
        total++; if (ram[15'h2222] !== ref_mem[15'h2222]) begin bad++; $display("FAIL starve_mem got=%h exp=%h", ram[15'h2222], ref_mem[15'h2222]); end
        vif.bus_memw_l = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int we0;
        we0 = we_cycles;
        @(negedge clk);
        vif.cpu_slot = 1'b0;
        vif.bus_a = 15'h3333; vif.bus_d = 8'h99;
        vif.bus_memw_l = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (vif.bus_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_rdy got=%b exp=1", vif.bus_rdy); end
        total++; if (vif.ram_we_l !== 1'b1) begin bad++; $display("FAIL rstmid_we got=%b exp=1", vif.ram_we_l); end
        vif.bus_memw_l = 1'b1;
        vif.cpu_slot = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (we_cycles != we0) begin bad++; $display("FAIL rstmid_nowrite got=%0d exp=0", we_cycles - we0); end
        total++; if (ram[15'h3333] !== ref_mem[15'h3333]) begin bad++; $display("FAIL rstmid_mem got=%h exp=%h", ram[15'h3333], ref_mem[15'h3333]); end
    endtask

    task automatic test_no_cs();
        int highs, we0;
        highs = 0; we0 = we_cycles;
        @(negedge clk);
        vif.bus_mem_cs = 1'b0;
        vif.bus_memw_l = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (vif.bus_rdy !== 1'b1) highs++;
        end
        vif.bus_memw_l = 1'b1;
        repeat (4) @(negedge clk);
        vif.bus_mem_cs = 1'b1;
        total++; if (highs != 0 || we_cycles != we0) begin bad++; $display("FAIL nocs_ignored got=%0d waits %0d writes exp=0 0", highs, we_cycles - we0); end
    endtask

    task automatic test_random();
        int lo, dc, rdp, we0, nwr, diffs; logic [7:0] rd; bit to, wr; logic [AB-1:0] a; logic [7:0] d;
        we0 = we_cycles; nwr = 0; diffs = 0;
        for (int t = 0; t < 40; t++) begin
            wr = ($urandom_range(0, 1) == 1);
            a  = AB'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) a = a | 15'h7FE0;
            d  = 8'($urandom);
            run_cpu(wr, a, d, 1'b1, lo, dc, rdp, rd, to);
            total++; if (to) begin bad++; $display("FAIL rand_timeout t=%0d got=timeout exp=ready", t); end
            if (wr) begin
                ref_mem[a] = d;
                nwr++;
            end else begin
                total++; if (rd !== ref_mem[a]) begin bad++; $display("FAIL rand_read t=%0d a=%h got=%h exp=%h", t, a, rd, ref_mem[a]); end
            end
        end
        vif.video_req = 1'b0;
        vif.cpu_slot = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < MEM_WORDS; i++) if (ram[i] !== ref_mem[i]) diffs++;
        total++; if (diffs != 0) begin bad++; $display("FAIL rand_mem got=%0d differing words exp=0", diffs); end
        total++; if (we_cycles - we0 != nwr) begin bad++; $display("FAIL rand_we_pulses got=%0d exp=%0d", we_cycles - we0, nwr); end
`ifndef CGA_SNOW_EN
        total++; if (we_clash != 0) begin bad++; $display("FAIL we_during_video got=%0d exp=0", we_clash); end
`endif
    endtask

    task automatic test_snow();
`ifdef CGA_SNOW_EN
        int lo, s0; bit seen_low, to;
        s0 = snow_cycles; lo = 0; seen_low = 1'b0; to = 1'b1;
        @(negedge clk);
        vif.video_req = 1'b1;
        vif.video_addr = 15'h0111;
        vif.bus_a = 15'h0ABC; vif.bus_d = 8'hE1;
        vif.bus_memw_l = 1'b0;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            if (n == 4) begin
                total++; if (vif.ram_a !== 15'h0ABC || vif.snow !== 1'b1 || vif.ram_we_l !== 1'b0) begin
                    bad++; $display("FAIL snow_access got=a:%h snow:%b we:%b exp=a:0abc snow:1 we:0", vif.ram_a, vif.snow, vif.ram_we_l);
                end
            end
            if (vif.bus_rdy === 1'b0) begin
                seen_low = 1'b1;
                lo++;
            end else if (seen_low) begin
                to = 1'b0;
                break;
            end
        end
        ref_mem[15'h0ABC] = 8'hE1;
        total++; if (to || lo != 2) begin bad++; $display("FAIL snow_wait_cycles got=%0d exp=2", lo); end
        total++; if (snow_cycles - s0 != 1) begin bad++; $display("FAIL snow_pulses got=%0d exp=1", snow_cycles - s0); end
        total++; if (ram[15'h0ABC] !== 8'hE1) begin bad++; $display("FAIL snow_mem got=%h exp=e1", ram[15'h0ABC]); end
        vif.bus_memw_l = 1'b1;
        vif.video_req = 1'b0;
        repeat (4) @(negedge clk);
`else
        total++; if (snow_cycles != 0) begin bad++; $display("FAIL snow_idle got=%0d exp=0", snow_cycles); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        vif.video_req  = 1'b0;
        vif.video_addr = '0;
        vif.cpu_slot   = 1'b1;
        vif.bus_mem_cs = 1'b1;
        vif.bus_a      = '0;
        vif.bus_memr_l = 1'b1;
        vif.bus_memw_l = 1'b1;
        vif.bus_d      = 8'h00;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ref_mem[i] = 8'($urandom);
            ram[i] <= ref_mem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_read_abort();
`ifndef CGA_SNOW_EN
        test_slot_starved();
        test_reset_mid();
`endif
        test_no_cs();
        test_random();
        test_snow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
